fft_r2sdf_stage: RTL and testbench

One radix-2 single-path delay-feedback (R2SDF) decimation-in-frequency butterfly stage of the 32-point FFT datapath. LOG_DEPTH=4,3,2,1,0 instances are cascaded (stage 1..5). The last stage feeds the bit-reversal reorder block, which takes 32 contiguous bit-reversed samples per frame. Each stage takes a streaming complex sample flow with a valid strobe, performs butterfly plus twiddle rotation, and emits a streaming flow with the same strobe convention.

---
 rtl/fft_r2sdf_stage.sv | 123 ++++++++++++
 tb/tb_fft_r2sdf_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fft_r2sdf_stage.sv
// fft_r2sdf_stage: one radix-2 SDF decimation-in-frequency butterfly stage with twiddle rotation
module fft_r2sdf_stage #(
  parameter int WIDTH     = 18,
  parameter int TWW       = 16,
  parameter int LOG_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] di_re,
  input  logic signed [WIDTH-1:0] di_im,
  input  logic                    di_en,
  output logic                    di_rdy,
  output logic signed [WIDTH-1:0] do_re,
  output logic signed [WIDTH-1:0] do_im,
  output logic                    do_en
);
  localparam int M = 1 << LOG_DEPTH;
  localparam int PW = WIDTH + TWW + 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2;
  localparam logic [LOG_DEPTH:0] HALF_LAST = (LOG_DEPTH+1)'(M - 1);
  localparam logic [LOG_DEPTH:0] LAST = (LOG_DEPTH+1)'(2 * M - 1);
  localparam logic signed [PW-1:0] MAXV = PW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
  localparam logic signed [PW-1:0] MINV = ~MAXV;
  localparam logic signed [TWW-1:0] COS_T [16] = '{
    16'sd16384, 16'sd16069, 16'sd15137, 16'sd13623, 16'sd11585, 16'sd9102, 16'sd6270, 16'sd3196,
    16'sd0, -16'sd3196, -16'sd6270, -16'sd9102, -16'sd11585, -16'sd13623, -16'sd15137, -16'sd16069};
  localparam logic signed [TWW-1:0] NSIN_T [16] = '{
    16'sd0, -16'sd3196, -16'sd6270, -16'sd9102, -16'sd11585, -16'sd13623, -16'sd15137, -16'sd16069,
    -16'sd16384, -16'sd16069, -16'sd15137, -16'sd13623, -16'sd11585, -16'sd9102, -16'sd6270, -16'sd3196};
  logic [1:0] state_q, state_d;
  logic [LOG_DEPTH:0] cnt_q, cnt_d;
  logic pend_q, pend_d;
  logic signed [WIDTH-1:0] dl_re_q [M];
  logic signed [WIDTH-1:0] dl_im_q [M];
  logic drain, adv, second;
  logic [3:0] k;
  logic signed [WIDTH:0] a_re, a_im, b_re, b_im;
  logic signed [WIDTH-1:0] sum_re, sum_im, dif_re, dif_im;
  logic signed [WIDTH-1:0] s1_re_q, s1_im_q;
  logic [3:0] s1_k_q;
  logic s1_v_q, s2_v_q;
  logic signed [PW-1:0] xr, xi, wr, wi, m_re_q, m_im_q;

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] s;
    s = v >>> (TWW - 2);
    return s > MAXV ? MAXV[WIDTH-1:0] : s < MINV ? MINV[WIDTH-1:0] : s[WIDTH-1:0];
  endfunction

  assign drain = state_q == DRAIN;
  assign di_rdy = !drain;
  assign adv = drain | di_en;
  assign second = cnt_q[LOG_DEPTH];
  // twiddle index: position within the half, scaled onto the 32-point circle
  assign k = 4'(32'(cnt_q) << (4 - LOG_DEPTH));
  assign a_re = (WIDTH+1)'(dl_re_q[M-1]);
  assign a_im = (WIDTH+1)'(dl_im_q[M-1]);
  assign b_re = (WIDTH+1)'(di_re);
  assign b_im = (WIDTH+1)'(di_im);
  assign sum_re = WIDTH'((a_re + b_re) >>> 1);
  assign sum_im = WIDTH'((a_im + b_im) >>> 1);
  assign dif_re = WIDTH'((a_re - b_re) >>> 1);
  assign dif_im = WIDTH'((a_im - b_im) >>> 1);
  assign xr = PW'(s1_re_q);
  assign xi = PW'(s1_im_q);
  assign wr = PW'(COS_T[s1_k_q]);
  assign wi = PW'(NSIN_T[s1_k_q]);

  always_comb begin
    cnt_d = adv ? (drain && cnt_q == HALF_LAST ? '0 : cnt_q + 1'b1) : cnt_q;
    pend_d = drain && cnt_q == HALF_LAST ? 1'b0 : (adv && cnt_q == LAST) ? 1'b1 : pend_q;
    state_d = drain ? (cnt_q == HALF_LAST ? IDLE : DRAIN)
            : (cnt_q == '0 && pend_q && !di_en) ? DRAIN : di_en ? RUN : state_q;
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      dl_re_q[0] <= second ? dif_re : di_re;
      dl_im_q[0] <= second ? dif_im : di_im;
      for (int i = 1; i < M; i++) begin
        dl_re_q[i] <= dl_re_q[i-1];
        dl_im_q[i] <= dl_im_q[i-1];
      end
    end
  end

  // sums take k=0, an exact identity rotation, so both paths share one pipeline
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pend_q <= 1'b0;
      s1_re_q <= '0;
      s1_im_q <= '0;
      s1_k_q <= '0;
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      m_re_q <= '0;
      m_im_q <= '0;
      do_re <= '0;
      do_im <= '0;
      do_en <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      s1_v_q <= adv & (second | pend_q);
      if (adv) begin
        s1_re_q <= second ? sum_re : dl_re_q[M-1];
        s1_im_q <= second ? sum_im : dl_im_q[M-1];
        s1_k_q <= second ? 4'd0 : k;
      end
      s2_v_q <= s1_v_q;
      m_re_q <= xr * wr - xi * wi;
      m_im_q <= xr * wi + xi * wr;
      do_en <= s2_v_q;
      if (s2_v_q) begin
        do_re <= sat(m_re_q);
        do_im <= sat(m_im_q);
      end
    end
  end
endmodule

// File: tb/tb_fft_r2sdf_stage.sv
// tb_fft_r2sdf_stage: directed checks of the SDF stage at LOG_DEPTH=4 and LOG_DEPTH=0
module tb_fft_r2sdf_stage;
  logic clk = 1'b0;
  logic rst;
  logic signed [17:0] a_re, a_im, a_ore, a_oim, b_re, b_im, b_ore, b_oim;
  logic a_en, a_rdy, a_oen, b_en, b_rdy, b_oen;
  logic signed [17:0] fr_re [32];
  logic signed [17:0] fr_im [32];
  logic [35:0] qa[$];
  logic [35:0] exq[$];
  int ta[$];
  int cyc = 0, rdy_low = 0, t17 = 0, n_tests = 0, n_fail = 0;

  fft_r2sdf_stage #(.WIDTH(18), .TWW(16), .LOG_DEPTH(4)) u4 (
    .clk(clk), .rst(rst), .di_re(a_re), .di_im(a_im), .di_en(a_en), .di_rdy(a_rdy),
    .do_re(a_ore), .do_im(a_oim), .do_en(a_oen));
  fft_r2sdf_stage #(.WIDTH(18), .TWW(16), .LOG_DEPTH(0)) u0 (
    .clk(clk), .rst(rst), .di_re(b_re), .di_im(b_im), .di_en(b_en), .di_rdy(b_rdy),
    .do_re(b_ore), .do_im(b_oim), .do_en(b_oen));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (a_oen) begin
      qa.push_back({a_ore, a_oim});
      ta.push_back(cyc);
    end
    if (!a_rdy) rdy_low++;
  end

  function automatic logic [35:0] pk(input int re, input int im);
    return {18'(re), 18'(im)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    a_en = 1'b0;
    a_re = '0;
    a_im = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 32; i++) begin
      fr_re[i] = '0;
      fr_im[i] = '0;
    end
  endtask

  task automatic play(input int n);
    for (int i = 0; i < n; i++) begin
      a_en = 1'b1;
      a_re = fr_re[i];
      a_im = fr_im[i];
      tick();
      if (i == 16) t17 = cyc;
    end
    a_en = 1'b0;
  endtask

  task automatic zeros(input int n);
    exq.delete();
    for (int i = 0; i < n; i++) exq.push_back('0);
  endtask

  task automatic restart();
    qa.delete();
    ta.delete();
    rdy_low = 0;
  endtask

  task automatic cmp(input string tag);
    check({tag, " count"}, qa.size(), exq.size());
    for (int i = 0; i < exq.size() && i < qa.size(); i++)
      check($sformatf("%s[%0d]", tag, i), qa[i], exq[i]);
  endtask

  initial begin
    rst = 1'b0;
    a_en = 1'b0; a_re = '0; a_im = '0;
    b_en = 1'b0; b_re = '0; b_im = '0;
    tick();
    check("rst do_en", a_oen, 0);
    check("rst do_re", a_ore, 0);
    check("rst do_im", a_oim, 0);
    check("rst di_rdy", a_rdy, 1);
    check("rst0 di_rdy", b_rdy, 1);
    check("rst0 do_en", b_oen, 0);
    tick();
    rst = 1'b1;
    tick();
    // pairwise butterfly: (1000,0),(200,0) -> 600 then 400 after a one-cycle drain
    b_en = 1'b1; b_re = 18'sd1000; tick();
    b_re = 18'sd200; tick();
    b_en = 1'b0; b_re = '0; tick();
    check("ld0 rdy low", b_rdy, 0);
    check("ld0 early en", b_oen, 0);
    tick();
    check("ld0 rdy back", b_rdy, 1);
    check("ld0 sum en", b_oen, 1);
    check("ld0 sum re", b_ore, 600);
    check("ld0 sum im", b_oim, 0);
    tick();
    check("ld0 gap en", b_oen, 0);
    tick();
    check("ld0 dif en", b_oen, 1);
    check("ld0 dif re", b_ore, 400);
    check("ld0 dif im", b_oim, 0);
    tick();
    check("ld0 end en", b_oen, 0);
    // impulse frame
    restart();
    clear_frame();
    fr_re[0] = 18'sd8192;
    play(32);
    idle(40);
    zeros(32);
    exq[0] = pk(4096, 0);
    exq[16] = pk(4096, 0);
    cmp("impulse");
    check("impulse latency", qa.size() > 0 ? ta[0] - t17 : -1, 2);
    check("impulse drain rdy", rdy_low, 16);
    // back-to-back frames: impulse then x8=2000, no gap
    restart();
    play(32);
    clear_frame();
    fr_re[8] = 18'sd2000;
    play(32);
    check("b2b rdy during", rdy_low, 0);
    idle(40);
    zeros(64);
    exq[0] = pk(4096, 0);
    exq[16] = pk(4096, 0);
    exq[40] = pk(1000, 0);
    exq[56] = pk(0, -1000);
    cmp("b2b");
    check("b2b contiguous", qa.size() == 64 ? ta[47] - ta[0] : -1, 47);
    check("b2b drain rdy", rdy_low, 16);
    // saturation: diff (-131072,-131072) rotated by W32^4
    restart();
    clear_frame();
    fr_re[4] = -18'sd131072; fr_im[4] = -18'sd131072;
    fr_re[20] = 18'sd131071; fr_im[20] = 18'sd131071;
    play(32);
    idle(40);
    zeros(32);
    exq[4] = pk(-1, -1);
    exq[20] = pk(-131072, 0);
    cmp("sat");
    // reset in the middle of a frame at cnt=10
    restart();
    clear_frame();
    fr_re[0] = 18'sd8192;
    play(32);
    play(10);
    check("pre-rst do_en", a_oen, 1);
    rst = 1'b0;
    #2;
    check("mid-rst do_en", a_oen, 0);
    check("mid-rst do_re", a_ore, 0);
    check("mid-rst do_im", a_oim, 0);
    check("mid-rst di_rdy", a_rdy, 1);
    tick();
    tick();
    rst = 1'b1;
    restart();
    idle(30);
    check("post-rst quiet", qa.size(), 0);
    check("post-rst no drain", rdy_low, 0);
    restart();
    play(32);
    idle(40);
    zeros(32);
    exq[0] = pk(4096, 0);
    exq[16] = pk(4096, 0);
    cmp("after rst");
    check("after rst latency", qa.size() > 0 ? ta[0] - t17 : -1, 2);
    check("after rst drain rdy", rdy_low, 16);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
